// File: rtl/fw_clkgen_multi_if.sv
// Control, configuration and status bundle between the config register bank
// and the multi-channel bunch-crossing clock generator.
interface fw_clkgen_multi_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);
  logic                      enable;
  logic                      start;
  logic                      stop;
  logic [CNT_W-1:0]          cfg_period;
  logic [CNT_W-1:0]          cfg_high;
  logic [NUM_CH*CNT_W-1:0]   cfg_delay;
  logic [NUM_CH-1:0]         cfg_invert;
  logic [15:0]               cfg_burst_len;
  logic [NUM_CH-1:0]         clk_out;
  logic                      period_strobe;
  logic [15:0]               period_cnt;
  logic                      busy;
  logic                      done;
  logic                      cfg_err;

  modport master (
    output enable, start, stop, cfg_period, cfg_high, cfg_delay,
           cfg_invert, cfg_burst_len,
    input  clk_out, period_strobe, period_cnt, busy, done, cfg_err
  );

  modport slave (
    input  enable, start, stop, cfg_period, cfg_high, cfg_delay,
           cfg_invert, cfg_burst_len,
    output clk_out, period_strobe, period_cnt, busy, done, cfg_err
  );
endinterface

// File: rtl/fw_clkgen_multi.sv
// Multi-channel bunch-crossing clock generator. One shared period counter
// drives NUM_CH phase-shifted, optionally inverted clocks. Configuration is
// shadowed at period boundaries so a change never shortens or stretches a
// period already in progress.
module fw_clkgen_multi #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) (
  input  logic              fw_pl_clk1,
  input  logic              fw_rst_n,
  fw_clkgen_multi_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t                    state_p0;
  logic [CNT_W-1:0]          cnt_p0;
  logic [15:0]               pcnt_p0;
  logic [CNT_W-1:0]          per_s;
  logic [CNT_W-1:0]          high_s;
  logic [NUM_CH*CNT_W-1:0]   dly_s;
  logic [NUM_CH-1:0]         inv_s;
  logic [15:0]               burst_s;

  logic [NUM_CH-1:0]         clk_p1;
  logic                      strobe_p1;
  logic                      busy_p1;
  logic                      done_p1;
  logic                      err_p1;

  logic [NUM_CH-1:0]         raw;
  logic                      wrap;
  logic                      cfg_bad;
  logic [15:0]               pcnt_inc;

  // Channel phase relative to its delay, wrapped into 0..P-1; high while phase < H.
  function automatic logic ch_raw(input logic [CNT_W-1:0] cnt,
                                  input logic [CNT_W-1:0] dly,
                                  input logic [CNT_W-1:0] per,
                                  input logic [CNT_W-1:0] high);
    logic [CNT_W:0] ph;
    if (cnt >= dly) ph = {1'b0, cnt} - {1'b0, dly};
    else            ph = {1'b0, cnt} + {1'b0, per} - {1'b0, dly};
    return ph < {1'b0, high};
  endfunction

  // A configuration is unusable if the period is degenerate, the high time
  // does not fit inside it, or any delay falls outside the period.
  function automatic logic cfg_check(input logic [CNT_W-1:0]        per,
                                     input logic [CNT_W-1:0]        high,
                                     input logic [NUM_CH*CNT_W-1:0] dly);
    logic bad;
    bad = (per < CNT_W'(2)) || (high == '0) || (high >= per);
    for (int c = 0; c < NUM_CH; c++)
      if (dly[c*CNT_W +: CNT_W] >= per) bad = 1'b1;
    return bad;
  endfunction

  assign wrap     = (cnt_p0 == per_s - CNT_W'(1));
  assign pcnt_inc = pcnt_p0 + 16'd1;
  assign cfg_bad  = cfg_check(bus.cfg_period, bus.cfg_high, bus.cfg_delay);

  // Raw per-channel level for the current counter value.
  always_comb begin
    raw = '0;
    for (int c = 0; c < NUM_CH; c++)
      raw[c] = ch_raw(cnt_p0, dly_s[c*CNT_W +: CNT_W], per_s, high_s);
  end

  // ---- stage p0: run-state machine, period counter and shadow configuration
  always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      pcnt_p0  <= '0;
      per_s    <= '0;
      high_s   <= '0;
      dly_s    <= '0;
      inv_s    <= '0;
      burst_s  <= '0;
    end else if (!bus.enable) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          cnt_p0 <= '0;
          if (bus.start && !err_p1) begin
            state_p0 <= RUN;
            pcnt_p0  <= '0;
            per_s    <= bus.cfg_period;
            high_s   <= bus.cfg_high;
            dly_s    <= bus.cfg_delay;
            inv_s    <= bus.cfg_invert;
            burst_s  <= bus.cfg_burst_len;
          end
        end
        RUN, STOPPING: begin
          if (wrap) begin
            cnt_p0  <= '0;
            pcnt_p0 <= pcnt_inc;
            if (state_p0 == STOPPING || bus.stop ||
                (burst_s != 16'd0 && pcnt_inc == burst_s)) begin
              state_p0 <= IDLE;
            end else if (!err_p1) begin
              per_s   <= bus.cfg_period;
              high_s  <= bus.cfg_high;
              dly_s   <= bus.cfg_delay;
              inv_s   <= bus.cfg_invert;
              burst_s <= bus.cfg_burst_len;
            end
          end else begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
            if (state_p0 == RUN && bus.stop) state_p0 <= STOPPING;
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  // ---- stage p1: registered clock outputs, strobe, status and config check
  always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      clk_p1    <= '0;
      strobe_p1 <= 1'b0;
      busy_p1   <= 1'b0;
      done_p1   <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      clk_p1    <= (state_p0 != IDLE) ? (raw ^ inv_s) : '0;
      strobe_p1 <= (state_p0 != IDLE) && (cnt_p0 == '0);
      busy_p1   <= (state_p0 != IDLE);
      done_p1   <= busy_p1 && (state_p0 == IDLE);
      err_p1    <= cfg_bad;
    end
  end

  assign bus.clk_out       = clk_p1;
  assign bus.period_strobe = strobe_p1;
  assign bus.period_cnt    = pcnt_p0;
  assign bus.busy          = busy_p1;
  assign bus.done          = done_p1;
  assign bus.cfg_err       = err_p1;

endmodule

// File: tb/tb_fw_clkgen_multi.sv
// Bench for fw_clkgen_multi: directed scenarios with hand-computed
// expectations, then randomized control/config traffic, all compared every
// cycle against a period-arithmetic reference model.
module tb_fw_clkgen_multi;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fw_clkgen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  fw_clkgen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .fw_pl_clk1 (clk),
    .fw_rst_n   (rst_n),
    .bus        (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               m_run, m_stopping, m_k, m_pc;
  int               mP, mH, mB;
  int               mD [NUM_CH];
  logic [NUM_CH-1:0] mInv;
  bit               m_err;
  logic [NUM_CH-1:0] e_clk;
  bit               e_strobe, e_busy, e_done;

  function automatic bit live_err();
    int p, h;
    bit bad;
    p = int'(bus.cfg_period);
    h = int'(bus.cfg_high);
    bad = (p < 2) || (h == 0) || (h >= p);
    for (int c = 0; c < NUM_CH; c++)
      if (int'(bus.cfg_delay[c*CNT_W +: CNT_W]) >= p) bad = 1'b1;
    return bad;
  endfunction

  task automatic model_load();
    mP = int'(bus.cfg_period);
    mH = int'(bus.cfg_high);
    mB = int'(bus.cfg_burst_len);
    for (int c = 0; c < NUM_CH; c++) mD[c] = int'(bus.cfg_delay[c*CNT_W +: CNT_W]);
    mInv = bus.cfg_invert;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_stopping = 0; m_k = 0; m_pc = 0;
      mP = 0; mH = 0; mB = 0; mInv = '0; m_err = 1'b0;
      for (int c = 0; c < NUM_CH; c++) mD[c] = 0;
      e_clk = '0; e_strobe = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      // outputs this edge show the position reached before it
      e_done   = e_busy && (m_run == 0);
      e_busy   = (m_run != 0);
      e_strobe = (m_run != 0) && (m_k == 0);
      e_clk    = '0;
      if (m_run != 0)
        for (int c = 0; c < NUM_CH; c++)
          e_clk[c] = (((((m_k - mD[c]) % mP) + mP) % mP) < mH) ^ mInv[c];
      // advance the run
      if (!bus.enable) begin
        m_run = 0; m_stopping = 0; m_k = 0;
      end else if (m_run == 0) begin
        if (bus.start && !m_err) begin
          m_run = 1; m_stopping = 0; m_k = 0; m_pc = 0;
          model_load();
        end
      end else if (m_k == mP - 1) begin
        m_pc = (m_pc + 1) % 65536;
        m_k  = 0;
        if (m_stopping != 0 || bus.stop || (mB != 0 && m_pc == mB)) begin
          m_run = 0; m_stopping = 0;
        end else if (!m_err) begin
          model_load();
        end
      end else begin
        m_k++;
        if (bus.stop) m_stopping = 1;
      end
      m_err = live_err();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("clk_out",       32'(bus.clk_out),       32'(e_clk));
      chk("period_strobe", 32'(bus.period_strobe), 32'(e_strobe));
      chk("period_cnt",    32'(bus.period_cnt),    32'(m_pc));
      chk("busy",          32'(bus.busy),          32'(e_busy));
      chk("done",          32'(bus.done),          32'(e_done));
      chk("cfg_err",       32'(bus.cfg_err),       32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int p, input int h, input int d0, input int d1,
                         input int inv, input int bl);
    bus.cfg_period    = CNT_W'(p);
    bus.cfg_high      = CNT_W'(h);
    bus.cfg_delay     = {CNT_W'(d1), CNT_W'(d0)};
    bus.cfg_invert    = NUM_CH'(inv);
    bus.cfg_burst_len = 16'(bl);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic to_idle();
    bus.enable = 1'b0;
    cyc(1);
    bus.enable = 1'b1;
    cyc(2);
  endtask

  task automatic rand_cfg(input bit allow_bad);
    int p, h, d0, d1;
    p  = $urandom_range(2, 20);
    h  = $urandom_range(1, p - 1);
    d0 = $urandom_range(0, p - 1);
    d1 = $urandom_range(0, p - 1);
    if (allow_bad && $urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 3))
        0: h = 0;
        1: h = p + $urandom_range(0, 3);
        2: d1 = p + $urandom_range(0, 2);
        default: p = $urandom_range(0, 1);
      endcase
    end
    set_cfg(p, h, d0, d1, $urandom_range(0, 3), $urandom_range(0, 4));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [19:0] v0, v1, vs;
    int nbusy, nhigh, ndone, first_done, k_done, since_cfg, r;
    bit saw_busy, saw_done;

    rst_n = 1'b0;
    bus.enable = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    set_cfg(10, 5, 0, 2, 0, 0);
    cyc(3);
    chk("rst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_pcnt",    32'(bus.period_cnt), 32'd0);
    chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    bus.enable = 1'b1;
    cyc(2);

    // P=10 H=5 D0=0 D1=2 free-run
    chk("s1_cfg_err", 32'(bus.cfg_err), 32'd0);
    do_start();
    v0 = '0; v1 = '0; vs = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      v0[i] = bus.clk_out[0]; v1[i] = bus.clk_out[1]; vs[i] = bus.period_strobe;
    end
    chk("s1_ch0_pattern", 32'(v0), 32'h07C1F);
    chk("s1_ch1_pattern", 32'(v1), 32'h1F07C);
    chk("s1_strobe",      32'(vs), 32'h00401);

    // stop sampled on cnt=3: period completes, done 7 edges later
    cyc(3);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    k_done = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.done && k_done < 0) k_done = k;
    end
    chk("stop_mid_done_lat", 32'(k_done), 32'd7);
    chk("stop_mid_pcnt",     32'(bus.period_cnt), 32'd3);

    // stop sampled on cnt=9: straight to IDLE at the wrap
    do_start();
    cyc(9);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    @(negedge clk);
    chk("stop_wrap_done", 32'(bus.done), 32'd1);
    chk("stop_wrap_busy", 32'(bus.busy), 32'd0);
    chk("stop_wrap_pcnt", 32'(bus.period_cnt), 32'd1);
    cyc(2);

    // D1=8 with inversion
    set_cfg(10, 5, 0, 8, 2, 0);
    cyc(2);
    do_start();
    v1 = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v1[i] = bus.clk_out[1];
    end
    chk("s2_ch1_inverted", 32'(v1), 32'h000F8);

    // enable dropped mid-run
    cyc(2);
    bus.enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("en_drop_done", 32'(bus.done),    32'd1);
    chk("en_drop_clk",  32'(bus.clk_out), 32'd0);
    chk("en_drop_busy", 32'(bus.busy),    32'd0);
    bus.enable = 1'b1;
    cyc(2);

    // burst of 3 periods, P=4
    set_cfg(4, 2, 0, 0, 0, 3);
    cyc(2);
    do_start();
    nbusy = 0; nhigh = 0; ndone = 0; first_done = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nbusy += int'(bus.busy);
      nhigh += int'(bus.clk_out[0]);
      ndone += int'(bus.done);
      if (bus.done && first_done < 0) first_done = i;
    end
    chk("burst_busy_ticks", 32'(nbusy), 32'd12);
    chk("burst_high_ticks", 32'(nhigh), 32'd6);
    chk("burst_done_count", 32'(ndone), 32'd1);
    chk("burst_done_index", 32'(first_done), 32'd12);
    chk("burst_pcnt",       32'(bus.period_cnt), 32'd3);

    // H changed 5->3 at cnt=4 takes effect next period
    set_cfg(10, 5, 0, 0, 0, 0);
    cyc(2);
    do_start();
    v0 = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      v0[i] = bus.clk_out[0];
      if (i == 3) bus.cfg_high = 8'd3;
    end
    chk("hchg_pattern", 32'(v0), 32'h01C1F);

    // H=12 with P=10: error flagged, shadow kept
    bus.cfg_high = 8'd12;
    cyc(2);
    chk("herr_cfg_err", 32'(bus.cfg_err), 32'd1);
    nhigh = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nhigh += int'(bus.clk_out[0]);
    end
    chk("herr_shadow_kept", 32'(nhigh), 32'd3);
    to_idle();
    saw_busy = 1'b0; saw_done = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_busy |= bus.busy;
      saw_done |= bus.done;
    end
    chk("herr_start_ignored_busy", 32'(saw_busy), 32'd0);
    chk("herr_start_ignored_done", 32'(saw_done), 32'd0);

    // reset pulsed mid-burst
    set_cfg(4, 2, 1, 3, 0, 5);
    cyc(2);
    do_start();
    cyc(6);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_clk",  32'(bus.clk_out),    32'd0);
    chk("rst_mid_busy", 32'(bus.busy),       32'd0);
    chk("rst_mid_pcnt", 32'(bus.period_cnt), 32'd0);
    chk("rst_mid_strb", 32'(bus.period_strobe), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw_done |= bus.done;
    end
    chk("rst_mid_no_done", 32'(saw_done), 32'd0);

    // randomized traffic
    since_cfg = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      r = $urandom_range(0, 99);
      if (!bus.enable) begin
        if (r < 40) bus.enable = 1'b1;
      end else if (r < 2) begin
        bus.enable = 1'b0;
      end else if (r < 9 && since_cfg >= 2) begin
        bus.start = 1'b1;
      end else if (r < 12) begin
        bus.stop = 1'b1;
      end else if (r < 15) begin
        rand_cfg(m_run == 0);
        since_cfg = 0;
      end
      since_cfg++;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
